// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction field positions and the datapath control word.
package ctrl_pkg;
  localparam int INSTR_LEN = 20;

  localparam int OPC_HI = 19, OPC_LO = 16;
  localparam int ALU_HI = 15, ALU_LO = 13;
  localparam int DST_HI = 12, DST_LO = 11;
  localparam int SA_HI  = 10, SA_LO  = 9;
  localparam int SB_HI  = 8,  SB_LO  = 7;
  localparam int CAL_HI = 6,  CAL_LO = 3;

  localparam logic [3:0] OPC_NOP  = 4'd0;
  localparam logic [3:0] OPC_IN   = 4'd1;
  localparam logic [3:0] OPC_ALU  = 4'd2;
  localparam logic [3:0] OPC_CMP  = 4'd3;
  localparam logic [3:0] OPC_OUT  = 4'd4;
  localparam logic [3:0] OPC_JMP  = 4'd5;
  localparam logic [3:0] OPC_JZ   = 4'd6;
  localparam logic [3:0] OPC_JNZ  = 4'd7;
  localparam logic [3:0] OPC_HALT = 4'd8;

  typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} state_t;

  typedef struct packed {
    logic       ie;
    logic       ze;
    logic       oe;
    logic       we;
    logic       rae;
    logic       rbe;
    logic [1:0] wa;
    logic [1:0] raa;
    logic [1:0] rba;
    logic [2:0] op;
    logic [3:0] cal;
  } ctrl_t;
endpackage

// File: rtl/ctrl_if.sv
// Bus between the control unit, instruction memory, I/O handshake and datapath.
interface ctrl_if #(parameter int ADDR_LEN = 8);
  logic [ADDR_LEN-1:0] InstrAddr;
  logic [19:0]         InstrData;
  logic                InValid;
  logic                InAck;
  logic                OutValid;
  logic                Halted;
  logic                Q;
  logic                IE, ZE, OE, WE, RAE, RBE;
  logic [1:0]          WA, RAA, RBA;
  logic [2:0]          OP;
  logic [3:0]          Cal_value;

  modport master (
    output InstrAddr, InAck, OutValid, Halted,
    output IE, ZE, OE, WE, RAE, RBE, WA, RAA, RBA, OP, Cal_value,
    input  InstrData, InValid, Q
  );

  modport slave (
    input  InstrAddr, InAck, OutValid, Halted,
    input  IE, ZE, OE, WE, RAE, RBE, WA, RAA, RBA, OP, Cal_value,
    output InstrData, InValid, Q
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of the instruction register into datapath controls.
// Everything is zero unless the FSM is in an active EXEC cycle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [INSTR_LEN-1:0] i_ir,
  input  logic                 i_exec,
  input  logic                 i_in_valid,
  input  logic                 i_q,
  output ctrl_t                o_ctrl,
  output logic                 o_jump,
  output logic                 o_in_ack,
  output logic                 o_out_valid
);
  logic [3:0] w_opc;
  logic       w_unused;

  assign w_opc    = i_ir[OPC_HI:OPC_LO];
  // Low bits only matter as part of a jump target, which the top consumes.
  assign w_unused = ^i_ir[2:0];

  always_comb begin
    o_ctrl      = '0;
    o_jump      = 1'b0;
    o_in_ack    = 1'b0;
    o_out_valid = 1'b0;
    if (i_exec) begin
      case (w_opc)
        OPC_IN: begin
          o_ctrl.wa = i_ir[DST_HI:DST_LO];
          if (i_in_valid) begin
            o_ctrl.ie = 1'b1;
            o_ctrl.we = 1'b1;
            o_in_ack  = 1'b1;
          end
        end
        OPC_ALU, OPC_CMP, OPC_OUT: begin
          o_ctrl.rae = 1'b1;
          o_ctrl.rbe = 1'b1;
          o_ctrl.raa = i_ir[SA_HI:SA_LO];
          o_ctrl.rba = i_ir[SB_HI:SB_LO];
          o_ctrl.op  = i_ir[ALU_HI:ALU_LO];
          o_ctrl.cal = i_ir[CAL_HI:CAL_LO];
          if (w_opc == OPC_OUT) begin
            o_ctrl.oe   = 1'b1;
            o_out_valid = 1'b1;
          end else begin
            o_ctrl.ze = 1'b1;
            if (w_opc == OPC_ALU) begin
              o_ctrl.we = 1'b1;
              o_ctrl.wa = i_ir[DST_HI:DST_LO];
            end
          end
        end
        OPC_JMP: o_jump = 1'b1;
        OPC_JZ:  o_jump = i_q;
        OPC_JNZ: o_jump = ~i_q;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle FETCH/LOAD/EXEC sequencer owning the PC, IR and FSM.
// Reset masks every output combinationally so a stalled IN or HALT never leaks.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ADDR_LEN = 8
) (
  input  logic Clock,
  input  logic Reset,
  ctrl_if.master bus
);
  logic [ADDR_LEN-1:0]  r_pc;
  logic [INSTR_LEN-1:0] r_ir;
  state_t               r_state, w_next;
  ctrl_t                w_ctrl;
  logic                 w_exec, w_jump, w_in_ack, w_out_valid;
  logic [3:0]           w_opc;

  assign w_opc  = r_ir[OPC_HI:OPC_LO];
  assign w_exec = (r_state == EXEC) && !Reset;

  ctrl_decode u_decode (
    .i_ir        (r_ir),
    .i_exec      (w_exec),
    .i_in_valid  (bus.InValid),
    .i_q         (bus.Q),
    .o_ctrl      (w_ctrl),
    .o_jump      (w_jump),
    .o_in_ack    (w_in_ack),
    .o_out_valid (w_out_valid)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD) begin
        r_ir <= bus.InstrData;
        r_pc <= r_pc + ADDR_LEN'(1);
      end
      // A taken jump replaces the increment done in LOAD.
      if (w_exec && w_jump)
        r_pc <= r_ir[ADDR_LEN-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: w_next = LOAD;
      LOAD:  w_next = EXEC;
      EXEC: begin
        if (w_opc == OPC_HALT)
          w_next = HALT;
        else if (w_opc == OPC_IN && !w_in_ack)
          w_next = EXEC;
        else
          w_next = FETCH;
      end
      HALT:  w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  assign bus.InstrAddr = Reset ? '0 : r_pc;
  assign bus.Halted    = (r_state == HALT) && !Reset;
  assign bus.InAck     = w_in_ack;
  assign bus.OutValid  = w_out_valid;
  assign bus.IE        = w_ctrl.ie;
  assign bus.ZE        = w_ctrl.ze;
  assign bus.OE        = w_ctrl.oe;
  assign bus.WE        = w_ctrl.we;
  assign bus.RAE       = w_ctrl.rae;
  assign bus.RBE       = w_ctrl.rbe;
  assign bus.WA        = w_ctrl.wa;
  assign bus.RAA       = w_ctrl.raa;
  assign bus.RBA       = w_ctrl.rba;
  assign bus.OP        = w_ctrl.op;
  assign bus.Cal_value = w_ctrl.cal;
endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: single-instruction vector table with a
// scoreboard queue, plus hand sequences for stall, wrap, halt and reset cases.
module tb_ctrl_unit;
  import ctrl_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  ctrl_if #(.ADDR_LEN(8)) bus ();
  ctrl_unit #(.ADDR_LEN(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  always #5 Clock = ~Clock;

  logic [19:0] mem [256];
  always @(posedge Clock) bus.InstrData <= mem[bus.InstrAddr];

  int errs = 0;
  int checks = 0;

  typedef struct packed {
    ctrl_t c;
    logic  ack;
    logic  ov;
  } obs_t;

  typedef struct {
    logic [19:0] instr;
    logic        q;
    logic        inv;
    obs_t        exp;
    logic [7:0]  nxt;
    logic        hlt;
  } vec_t;

  vec_t vecs [12];
  obs_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.c.ie  = bus.IE;  o.c.ze  = bus.ZE;  o.c.oe  = bus.OE;
    o.c.we  = bus.WE;  o.c.rae = bus.RAE; o.c.rbe = bus.RBE;
    o.c.wa  = bus.WA;  o.c.raa = bus.RAA; o.c.rba = bus.RBA;
    o.c.op  = bus.OP;  o.c.cal = bus.Cal_value;
    o.ack   = bus.InAck;
    o.ov    = bus.OutValid;
    return o;
  endfunction

  function automatic obs_t ob(input logic ie, ze, oe, we, rae, rbe,
                              input logic [1:0] wa, raa, rba,
                              input logic [2:0] op, input logic [3:0] cal,
                              input logic ack, ov);
    obs_t o;
    o.c.ie = ie; o.c.ze = ze; o.c.oe = oe; o.c.we = we; o.c.rae = rae; o.c.rbe = rbe;
    o.c.wa = wa; o.c.raa = raa; o.c.rba = rba; o.c.op = op; o.c.cal = cal;
    o.ack = ack; o.ov = ov;
    return o;
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] opc, input logic [2:0] aop,
                                     input logic [1:0] dst, sa, sbb, input logic [3:0] cal);
    return {opc, aop, dst, sa, sbb, cal, 3'b000};
  endfunction

  function automatic logic [19:0] mkj(input logic [3:0] opc, input logic [7:0] tgt);
    return {opc, 8'h00, tgt};
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 20'h0;
  endtask

  // Caller is at a negedge; leaves Reset released at a negedge (FETCH of PC 0).
  task automatic go_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    obs_t z, e;
    z = '0;
    bus.InValid = 1'b0;
    bus.Q = 1'b0;
    clear_mem();

    //           instr                             q     inv   expected observation                                         next   halt
    vecs[0]  = '{mk(4'd0, 3'd7, 2'd3, 2'd3, 2'd3, 4'hF), 1'b0, 1'b0, z,                                                            8'h01, 1'b0};
    vecs[1]  = '{mk(4'd2, 3'd1, 2'd2, 2'd0, 2'd1, 4'h5), 1'b0, 1'b0, ob(0,1,0,1,1,1, 2'd2,2'd0,2'd1, 3'd1,4'h5, 0,0),              8'h01, 1'b0};
    vecs[2]  = '{mk(4'd3, 3'd4, 2'd3, 2'd2, 2'd3, 4'hA), 1'b0, 1'b0, ob(0,1,0,0,1,1, 2'd0,2'd2,2'd3, 3'd4,4'hA, 0,0),              8'h01, 1'b0};
    vecs[3]  = '{mk(4'd4, 3'd7, 2'd1, 2'd3, 2'd2, 4'hF), 1'b0, 1'b0, ob(0,0,1,0,1,1, 2'd0,2'd3,2'd2, 3'd7,4'hF, 0,1),              8'h01, 1'b0};
    vecs[4]  = '{mk(4'd1, 3'd5, 2'd3, 2'd1, 2'd1, 4'h3), 1'b0, 1'b1, ob(1,0,0,1,0,0, 2'd3,2'd0,2'd0, 3'd0,4'h0, 1,0),              8'h01, 1'b0};
    vecs[5]  = '{mkj(4'd5, 8'h20),                      1'b0, 1'b0, z,                                                            8'h20, 1'b0};
    vecs[6]  = '{mkj(4'd6, 8'h20),                      1'b1, 1'b0, z,                                                            8'h20, 1'b0};
    vecs[7]  = '{mkj(4'd6, 8'h20),                      1'b0, 1'b0, z,                                                            8'h01, 1'b0};
    vecs[8]  = '{mkj(4'd7, 8'h20),                      1'b0, 1'b0, z,                                                            8'h20, 1'b0};
    vecs[9]  = '{mkj(4'd7, 8'h20),                      1'b1, 1'b0, z,                                                            8'h01, 1'b0};
    vecs[10] = '{mk(4'd8, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0), 1'b0, 1'b0, z,                                                            8'h01, 1'b1};
    vecs[11] = '{mk(4'd12, 3'd6, 2'd2, 2'd1, 2'd3, 4'h9), 1'b1, 1'b1, z,                                                           8'h01, 1'b0};

    @(negedge Clock);
    for (int i = 0; i < 12; i++) begin
      clear_mem();
      mem[0] = vecs[i].instr;
      bus.Q = vecs[i].q;
      bus.InValid = vecs[i].inv;
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      #1;
      chk($sformatf("v%0d_rst_outs", i), 32'(sample()), 32'(z));
      chk($sformatf("v%0d_rst_addr", i), 32'(bus.InstrAddr), 32'h0);
      chk($sformatf("v%0d_rst_halt", i), 32'(bus.Halted), 32'h0);
      sb.push_back(vecs[i].exp);
      Reset = 1'b0;
      #1;
      chk($sformatf("v%0d_fetch_addr", i), 32'(bus.InstrAddr), 32'h0);
      @(negedge Clock); #1;
      chk($sformatf("v%0d_load_idle", i), 32'(sample()), 32'(z));
      @(negedge Clock); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_exec", i), 32'(sample()), 32'(e));
      @(negedge Clock); #1;
      chk($sformatf("v%0d_next_addr", i), 32'(bus.InstrAddr), 32'(vecs[i].nxt));
      chk($sformatf("v%0d_halted", i), 32'(bus.Halted), 32'(vecs[i].hlt));
      chk($sformatf("v%0d_post_idle", i), 32'(sample()), 32'(z));
      @(negedge Clock);
    end

    // IN at address 3 stalled four cycles, then acknowledged.
    clear_mem();
    mem[3] = mk(4'd1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h0);
    bus.InValid = 1'b0;
    bus.Q = 1'b0;
    go_reset();
    repeat (9) @(negedge Clock); #1;
    chk("in_fetch_addr", 32'(bus.InstrAddr), 32'h3);
    repeat (2) @(negedge Clock);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("in_stall%0d", k), 32'(sample()), 32'(ob(0,0,0,0,0,0, 2'd1,2'd0,2'd0, 3'd0,4'h0, 0,0)));
      @(negedge Clock);
    end
    bus.InValid = 1'b1;
    #1;
    chk("in_ack", 32'(sample()), 32'(ob(1,0,0,1,0,0, 2'd1,2'd0,2'd0, 3'd0,4'h0, 1,0)));
    @(negedge Clock);
    bus.InValid = 1'b0;
    #1;
    chk("in_next_addr", 32'(bus.InstrAddr), 32'h4);
    chk("in_next_idle", 32'(sample()), 32'(z));

    // Reset arriving mid-stall together with InValid must not acknowledge.
    @(negedge Clock);
    go_reset();
    repeat (11) @(negedge Clock); #1;
    chk("rs_stall", 32'(sample()), 32'(ob(0,0,0,0,0,0, 2'd1,2'd0,2'd0, 3'd0,4'h0, 0,0)));
    @(negedge Clock);
    Reset = 1'b1;
    bus.InValid = 1'b1;
    #1;
    chk("rs_no_ack", 32'(bus.InAck), 32'h0);
    chk("rs_outs", 32'(sample()), 32'(z));
    chk("rs_addr", 32'(bus.InstrAddr), 32'h0);
    repeat (2) @(negedge Clock);
    bus.InValid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("rs_restart_addr", 32'(bus.InstrAddr), 32'h0);
    repeat (3) @(negedge Clock); #1;
    chk("rs_second_fetch", 32'(bus.InstrAddr), 32'h1);

    // JMP to the last address, NOP there wraps the PC to 0.
    @(negedge Clock);
    clear_mem();
    mem[0] = mkj(4'd5, 8'hFF);
    go_reset();
    repeat (3) @(negedge Clock); #1;
    chk("wrap_jmp_addr", 32'(bus.InstrAddr), 32'hFF);
    repeat (3) @(negedge Clock); #1;
    chk("wrap_addr", 32'(bus.InstrAddr), 32'h0);

    // HALT holds for 20 cycles, then Reset mid-halt restarts from 0.
    @(negedge Clock);
    clear_mem();
    mem[0] = mk(4'd8, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0);
    go_reset();
    repeat (3) @(negedge Clock);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("halt%0d_flag", k), 32'(bus.Halted), 32'h1);
      chk($sformatf("halt%0d_addr", k), 32'(bus.InstrAddr), 32'h1);
      chk($sformatf("halt%0d_outs", k), 32'(sample()), 32'(z));
      @(negedge Clock);
    end
    Reset = 1'b1;
    #1;
    chk("halt_rst_flag", 32'(bus.Halted), 32'h0);
    chk("halt_rst_addr", 32'(bus.InstrAddr), 32'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("halt_restart_addr", 32'(bus.InstrAddr), 32'h0);
    chk("halt_restart_flag", 32'(bus.Halted), 32'h0);
    repeat (3) @(negedge Clock); #1;
    chk("halt_again_flag", 32'(bus.Halted), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
